// File: rtl/boss_hp_ctrl.sv
// Boss hit-point counter and HP-bar redraw sequencer: blanks the bar region, then
// hands a frozen HP to the bar drawer and forwards its pixels to the VGA adapter.
module boss_hp_ctrl #(
    parameter int unsigned MAX_HP     = 20,
    parameter int unsigned BAR_X0     = 131,
    parameter int unsigned BAR_Y0     = 6,
    parameter int unsigned BAR_H      = 4,
    parameter logic [2:0]  BG_COLOUR  = 3'b000,
    parameter logic [2:0]  BAR_COLOUR = 3'b100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       game_start,
    input  logic       hit,
    input  logic [2:0] hit_dmg,
    output logic [4:0] hp,
    output logic       boss_dead,
    output logic       busy,
    output logic       draw_start,
    output logic [4:0] draw_hp,
    input  logic       draw_done,
    input  logic [7:0] draw_x,
    input  logic [6:0] draw_y,
    input  logic       draw_en,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [4:0] HP_MAX  = 5'(MAX_HP);
    localparam logic [7:0] X_FIRST = 8'(BAR_X0);
    localparam logic [7:0] X_LAST  = 8'(BAR_X0 + MAX_HP);
    localparam logic [6:0] Y_FIRST = 7'(BAR_Y0);
    localparam logic [6:0] Y_LAST  = 7'(BAR_Y0 + BAR_H - 1);

    typedef enum logic [2:0] {IDLE, ERASE, START, WAIT, RELEASE} state_t;

    state_t     state, state_nxt;
    logic       pending;
    logic       hp_event;
    logic       erase_last;
    logic [4:0] hp_nxt;

    function automatic logic [4:0] sat_sub(input logic [4:0] a, input logic [2:0] b);
        logic signed [6:0] diff;
        diff = $signed({2'b00, a}) - $signed({4'b0000, b});
        return (diff < 0) ? 5'd0 : diff[4:0];
    endfunction

    assign hp_event   = game_start | hit;
    assign erase_last = (vga_x == X_LAST) && (vga_y == Y_LAST);
    assign busy       = (state != IDLE);

    always_comb begin
        hp_nxt = hp;
        if (game_start)
            hp_nxt = HP_MAX;
        else if (hit)
            hp_nxt = sat_sub(hp, hit_dmg);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // draw_start is Moore-decoded so it never depends combinationally on draw_done
    always_comb begin
        state_nxt  = state;
        draw_start = 1'b0;
        case (state)
            IDLE:    if (pending) state_nxt = ERASE;
            ERASE:   if (erase_last) state_nxt = (draw_hp != 5'd0) ? START : RELEASE;
            START: begin
                draw_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                draw_start = 1'b1;
                if (draw_done) state_nxt = RELEASE;
            end
            RELEASE: if (!draw_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hp        <= HP_MAX;
            boss_dead <= 1'b0;
            pending   <= 1'b1;
        end else begin
            hp        <= hp_nxt;
            boss_dead <= (hp_nxt == 5'd0);
            if (hp_event)
                pending <= 1'b1;
            else if (state == IDLE && pending)
                pending <= 1'b0;
        end
    end

    // vga_x/vga_y double as the erase walker while in ERASE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            draw_hp    <= 5'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'b000;
            vga_plot   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (pending) begin
                        draw_hp    <= hp;
                        vga_x      <= X_FIRST;
                        vga_y      <= Y_FIRST;
                        vga_colour <= BG_COLOUR;
                        vga_plot   <= 1'b1;
                    end
                end
                ERASE: begin
                    if (erase_last) begin
                        vga_plot <= 1'b0;
                    end else if (vga_x == X_LAST) begin
                        vga_x <= X_FIRST;
                        vga_y <= vga_y + 7'd1;
                    end else begin
                        vga_x <= vga_x + 8'd1;
                    end
                end
                START, WAIT: begin
                    vga_x      <= draw_x;
                    vga_y      <= draw_y;
                    vga_colour <= BAR_COLOUR;
                    vga_plot   <= draw_en & ~draw_done;
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end

endmodule
